// File: rtl/addr_wr_responder.sv
// -----------------------------------------------------------------------------
// addr_wr_responder
// Target-side responder for the addr/wr/en stimulus bus. Holds a 2**ADDR_W x
// DATA_W register file and services one access per cycle: a write when en=1 and
// wr=1, a registered read when en=1 and wr=0. It also keeps saturating
// access counters.
//
// Optional feature macro: WR_PROTECT_EN
//   When this macro is defined, the top address is a lock control register
//   instead of storage. While lock=1, writes to every other address are
//   dropped and err pulses for one cycle.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   en        in   access enable
//   wr        in   1 = write, 0 = read (ignored when en=0)
//   addr      in   access address [ADDR_W]
//   wdata     in   write data [DATA_W]
//   rdata     out  registered read data [DATA_W]
//   rvalid    out  one-cycle pulse qualifying rdata
//   wr_count  out  accepted writes, saturating [CNT_W]
//   rd_count  out  completed reads, saturating [CNT_W]
//   err       out  one-cycle pulse on a rejected write (tied 0 without protect)
// -----------------------------------------------------------------------------
module addr_wr_responder #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              rvalid_q,   rvalid_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic              mem_we_c;

`ifdef WR_PROTECT_EN
    localparam logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}};

    logic lock_q, lock_d;
    logic err_q,  err_d;
`endif

    // Access decode: next-state for read path, counters, lock and write strobe
    always_comb begin
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        mem_we_c   = 1'b0;
`ifdef WR_PROTECT_EN
        lock_d     = lock_q;
        err_d      = 1'b0;
`endif
        if (en) begin
            if (wr) begin
`ifdef WR_PROTECT_EN
                // Control-register writes are always accepted, even when locked
                if (addr == CTRL_ADDR) begin
                    lock_d = wdata[0];
                    if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
                end else if (lock_q) begin
                    err_d = 1'b1;
                end else begin
                    mem_we_c = 1'b1;
                    if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
                end
`else
                mem_we_c = 1'b1;
                if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
`endif
            end else begin
                rvalid_d = 1'b1;
                if (rd_count_q != '1) rd_count_d = rd_count_q + CNT_W'(1);
`ifdef WR_PROTECT_EN
                if (addr == CTRL_ADDR) rdata_d = DATA_W'(lock_q);
                else                   rdata_d = mem_q[addr];
`else
                rdata_d = mem_q[addr];
`endif
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
`ifdef WR_PROTECT_EN
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
`ifdef WR_PROTECT_EN
            lock_q     <= lock_d;
            err_q      <= err_d;
`endif
        end
    end

    // Register file; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we_c) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`ifdef WR_PROTECT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_addr_wr_responder.sv
module tb_addr_wr_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [5:0]  addr = '0;
    logic [7:0]  wdata = '0;

    logic [7:0]  rdata;
    logic        rvalid;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic        err;

    logic [7:0]  rdata_s;
    logic        rvalid_s;
    logic [3:0]  wr_count_s;
    logic [3:0]  rd_count_s;
    logic        err_s;

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    addr_wr_responder dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .wr_count(wr_count), .rd_count(rd_count),
        .err(err)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    addr_wr_responder #(.ADDR_W(6), .DATA_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata_s), .rvalid(rvalid_s), .wr_count(wr_count_s), .rd_count(rd_count_s),
        .err(err_s)
    );

    // Apply one bus cycle and settle just after the edge
    task automatic cyc(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
        en = e; wr = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; wr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        cyc(1, 0, 6'd0, 8'h00);
        checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL reset_rd0 got=%h/%b exp=00/1", rdata, rvalid); end
        cyc(1, 0, 6'd31, 8'h00);
        checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL reset_rd31 got=%h/%b exp=00/1", rdata, rvalid); end
        cyc(1, 0, 6'd63, 8'h00);
        checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL reset_rd63 got=%h/%b exp=00/1", rdata, rvalid); end
        cyc(0, 0, 6'd0, 8'h00);
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL reset_rd_count got=%0d exp=3", rd_count); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_idle_rvalid got=%b exp=0", rvalid); end
    endtask

    task automatic test_write_read();
        do_reset();
        cyc(1, 1, 6'h12, 8'hA5);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got=%b exp=0", rvalid); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count got=%0d exp=1", wr_count); end
        cyc(1, 0, 6'h12, 8'h00);
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got=%h exp=a5", rdata); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", rvalid); end
        checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count got=%0d exp=1", rd_count); end
    endtask

    task automatic test_idle_hold();
        // Continues from test_write_read: wr_count=1, rd_count=1
        cyc(1, 1, 6'h20, 8'h3C);
        cyc(1, 0, 6'h20, 8'h00);
        checks++; if (rdata !== 8'h3C || rvalid !== 1'b1) begin errors++; $display("FAIL idle_pre got=%h/%b exp=3c/1", rdata, rvalid); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 6'h20, 8'hFF);
            checks++; if (rvalid !== 1'b0 || rdata !== 8'h3C) begin errors++; $display("FAIL idle_hold[%0d] got=%h/%b exp=3c/0", i, rdata, rvalid); end
        end
        checks++; if (wr_count !== 16'd2 || rd_count !== 16'd2) begin errors++; $display("FAIL idle_counts got=%0d/%0d exp=2/2", wr_count, rd_count); end
        cyc(1, 0, 6'h20, 8'h00);
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL idle_no_write got=%h exp=3c", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        do_reset();
        // Write then immediately read each address; then burst-read all back
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'h11 * (i + 1));
            cyc(1, 1, 6'(i * 9), exp_d);
            cyc(1, 0, 6'(i * 9), 8'h00);
            checks++; if (rdata !== exp_d || rvalid !== 1'b1) begin errors++; $display("FAIL raw[%0d] got=%h/%b exp=%h/1", i, rdata, rvalid, exp_d); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'h11 * (i + 1));
            cyc(1, 0, 6'(i * 9), 8'h00);
            checks++; if (rdata !== exp_d || rvalid !== 1'b1) begin errors++; $display("FAIL burst[%0d] got=%h/%b exp=%h/1", i, rdata, rvalid, exp_d); end
        end
        cyc(0, 0, 6'd0, 8'h00);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL burst_end_rvalid got=%b exp=0", rvalid); end
        checks++; if (wr_count !== 16'd4 || rd_count !== 16'd8) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=4/8", wr_count, rd_count); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_c;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 6'(i), 8'(i));
            exp_c = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            checks++; if (wr_count_s !== exp_c) begin errors++; $display("FAIL sat_wr[%0d] got=%0d exp=%0d", i, wr_count_s, exp_c); end
        end
        checks++; if (wr_count !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", wr_count); end
        for (int i = 0; i < 17; i++) cyc(1, 0, 6'(i), 8'h00);
        checks++; if (rd_count_s !== 4'd15 || rdata_s !== 8'h10) begin errors++; $display("FAIL sat_rd got=%0d/%h exp=15/10", rd_count_s, rdata_s); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        cyc(1, 1, 6'h05, 8'h77);
        cyc(1, 0, 6'h05, 8'h00);
        checks++; if (rdata !== 8'h77 || rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%h/%b exp=77/1", rdata, rvalid); end
        #5 rst = 1'b1;
        #1;
        checks++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL mid_async got=%h/%b exp=00/0", rdata, rvalid); end
        checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin errors++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", wr_count, rd_count); end
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 6'h05, 8'h00);
        checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL mid_after got=%h/%b exp=00/1", rdata, rvalid); end
    endtask

`ifdef WR_PROTECT_EN
    task automatic test_protect();
        do_reset();
        cyc(1, 1, 6'd63, 8'h01);
        checks++; if (err !== 1'b0 || wr_count !== 16'd1) begin errors++; $display("FAIL prot_lock got=%b/%0d exp=0/1", err, wr_count); end
        cyc(1, 1, 6'd0, 8'hFF);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL prot_err got=%b exp=1", err); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL prot_count got=%0d exp=1", wr_count); end
        cyc(1, 0, 6'd0, 8'h00);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL prot_err_len got=%b exp=0", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL prot_dropped got=%h exp=00", rdata); end
        cyc(1, 0, 6'd63, 8'h00);
        checks++; if (rdata !== 8'h01) begin errors++; $display("FAIL prot_rd_ctrl got=%h exp=01", rdata); end
        cyc(1, 1, 6'd63, 8'h00);
        cyc(1, 1, 6'd0, 8'hFF);
        checks++; if (err !== 1'b0 || wr_count !== 16'd3) begin errors++; $display("FAIL prot_unlock got=%b/%0d exp=0/3", err, wr_count); end
        cyc(1, 0, 6'd0, 8'h00);
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL prot_accept got=%h exp=ff", rdata); end
    endtask
`else
    task automatic test_no_protect();
        do_reset();
        cyc(1, 1, 6'd63, 8'h01);
        cyc(1, 1, 6'd0, 8'hFF);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL noprot_err got=%b exp=0", err); end
        cyc(1, 0, 6'd0, 8'h00);
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL noprot_rd0 got=%h exp=ff", rdata); end
        cyc(1, 1, 6'd63, 8'h5A);
        cyc(1, 0, 6'd63, 8'h00);
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL noprot_rd63 got=%h exp=5a", rdata); end
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL noprot_count got=%0d exp=3", wr_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_idle_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_read();
`ifdef WR_PROTECT_EN
        test_protect();
`else
        test_no_protect();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addr_wr_responder.md
# addr_wr_responder

Target-side responder for the 6-bit `addr` / `wr` / `en` stimulus bus driven on the 25 MHz `clk` rising edge. It holds a 64-entry × 8-bit register file and services one access per cycle: a write when `en`=1 and `wr`=1, a registered read when `en`=1 and `wr`=0. It keeps saturating access counters and an optional write-protect lock. It is the DUT the stimulus tasks exercise in the testbenches.

## Interface
Parameters:
- `ADDR_W`, 6: address width; depth = 2**ADDR_W = 64.
- `DATA_W`, 8: data width.
- `CNT_W`, 16: access counter width.

Ports:
- `clk`  in  1  system clock, 25 MHz, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  access enable, sampled on posedge.
- `wr`  in  1  1 = write, 0 = read; ignored when `en`=0.
- `addr`  in  ADDR_W  access address.
- `wdata`  in  DATA_W  write data, sampled with `en`&`wr`.
- `rdata`  out  DATA_W  read data, registered.
- `rvalid`  out  1  one-cycle pulse qualifying `rdata`.
- `wr_count`  out  CNT_W  accepted writes, saturating.
- `rd_count`  out  CNT_W  completed reads, saturating.
- `err`  out  1  one-cycle pulse on a rejected write (protect feature only).

## Operation
- Reset, asynchronous and immediate: all 64 entries = 0, `rdata`=0, `rvalid`=0, `wr_count`=0, `rd_count`=0, `err`=0, lock=0.
- Per posedge with `rst`=0, a 3-way decode:
  - IDLE (`en`=0): no memory change; `rvalid`←0; `rdata` holds its last value; counters hold.
  - WRITE (`en`=1, `wr`=1): `mem[addr]`←`wdata`; `wr_count`←`wr_count`+1 unless all-ones; `rvalid`←0.
  - READ (`en`=1, `wr`=0): `rdata`←`mem[addr]`; `rvalid`←1; `rd_count`←`rd_count`+1 unless all-ones.
- The full 6-bit address space is valid. There is no out-of-range case, and no address wrap beyond the modulo-64 width.
- Read-after-write, same address, back-to-back: the read returns the newly written value.
- Counters saturate at 2**CNT_W−1 and never wrap. They clear only on reset.
- `rvalid` is never high for two cycles unless two consecutive READ cycles occur. Each read produces exactly one pulse.

## Timing
- Write latency 0: data is visible to a read issued on the next posedge.
- Read latency 1: for a READ sampled at edge N, `rdata` and `rvalid` are valid after edge N and until edge N+1.
- Throughput: one access per cycle, no back-pressure, no ready signal.
- Reset asserted mid-access: the in-flight read is discarded (`rvalid` forced 0), the write is lost, and the memory is cleared.
- `err` is high for exactly the cycle after the rejected write edge.

## Configuration
- `WR_PROTECT_EN` defined:
  - Address 63 is a control register. It is not stored in `mem`.
  - A write to 63 sets lock←`wdata[0]`.
  - A read of 63 returns {7'b0, lock}.
  - While lock=1, writes to addresses 0–62 are dropped: no memory change, `wr_count` holds, `err` pulses.
  - Writes to 63 are always accepted and counted.
- `WR_PROTECT_EN` undefined:
  - Address 63 is ordinary storage.
  - There is no lock.
  - `err` is tied 0.

## Test plan
- Reset check: assert `rst` for 2 cycles, then read addresses 0, 31 and 63 -> `rdata`=0x00 with `rvalid`=1 for each; `wr_count`=0; `rd_count`=3.
- Write/read-back: write 0xA5 to 0x12, then on the next cycle read 0x12 -> `rdata`=0xA5 one cycle later; `wr_count`=1; `rd_count`=1.
- Idle hold: after a read returns 0x3C, drive `en`=0 for 5 cycles -> `rvalid`=0 and `rdata` stays 0x3C; counters unchanged.
- Saturation: with CNT_W=4, issue 20 writes -> `wr_count`=15 and holds.
- Reset mid-read: read 0x05 (holding 0x77), then assert `rst` before the next edge -> `rvalid`=0 and `rdata`=0 immediately; a subsequent read of 0x05 returns 0x00.
- Protect (`WR_PROTECT_EN`): write 0x01 to 63, then write 0xFF to 0x00 -> `err` pulses for 1 cycle; a read of 0x00 returns 0x00; `wr_count`=1. Write 0x00 to 63, then 0xFF to 0x00 -> accepted, read returns 0xFF.
